// File: rtl/axi_burst_wr_master.sv
// AXI4 write-burst master: accepts one user request, issues AW, streams a W burst
// fetched from the user one word per handshake, then waits for the B response.
module axi_burst_wr_master #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 16,
  parameter int DATA_LEVEL = 2,
  parameter int WBURST_LEN = 8,
  parameter int RBURST_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  init_end,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic                  axi_wlast,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic                  wr_trig,
  input  logic [7:0]            wr_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_ready,
  output logic                  wr_done
);

  // DATA_LEVEL and RBURST_LEN carry no logic; they are only sanity-checked here.
  if (WBURST_LEN < 1 || WBURST_LEN > 255 || DATA_LEVEL < 1 || RBURST_LEN < 1) begin : g_param_check
    $error("axi_burst_wr_master: illegal burst parameters");
  end

  localparam logic [7:0] MAX_LEN = 8'(WBURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [7:0]              awlen_q, awlen_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              len_eff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      awaddr_q <= '0;
      awlen_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      awaddr_q <= awaddr_d;
      awlen_q  <= awlen_d;
      cnt_q    <= cnt_d;
    end
  end

  // Zero-length requests become one beat; oversize requests clamp to the max burst.
  always_comb begin
    len_eff = (wr_len == 8'd0) ? 8'd1 : wr_len;
    if (len_eff > MAX_LEN) len_eff = MAX_LEN;
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    awaddr_d = awaddr_q;
    awlen_d  = awlen_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_trig && wr_ready) begin
          awaddr_d = wr_addr;
          awlen_d  = len_eff - 8'd1;
          cnt_d    = '0;
          state_d  = S_AW;
        end
      end
      S_AW: begin
        if (axi_awready) state_d = S_W;
      end
      S_W: begin
        if (axi_wready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == awlen_q) state_d = S_B;
        end
      end
      S_B: begin
        if (axi_bvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    axi_awvalid = (state_q == S_AW);
    axi_awaddr  = awaddr_q;
    axi_awlen   = awlen_q;
    axi_wvalid  = (state_q == S_W);
    axi_wlast   = axi_wvalid && (cnt_q == awlen_q);
    axi_wdata   = wr_data;
    axi_bready  = (state_q == S_B);
    wr_data_en  = axi_wvalid && axi_wready;
    wr_ready    = (state_q == S_IDLE) && init_end;
    wr_done     = axi_bready && axi_bvalid;
  end

endmodule

// File: tb/tb_axi_burst_wr_master.sv
// Scoreboard bench for axi_burst_wr_master: stimulus pushes expected AW/W items,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_axi_burst_wr_master;

  localparam int AW = 27;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          init_end;
  logic          axi_awvalid, axi_awready;
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic          axi_wvalid, axi_wready, axi_wlast;
  logic [DW-1:0] axi_wdata;
  logic          axi_bvalid, axi_bready;
  logic          wr_trig;
  logic [7:0]    wr_len;
  logic [DW-1:0] wr_data;
  logic          wr_data_en;
  logic [AW-1:0] wr_addr;
  logic          wr_ready, wr_done;

  axi_burst_wr_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_LEVEL(2), .WBURST_LEN(8), .RBURST_LEN(8)
  ) dut (
    .clk(clk), .rstn(rstn), .init_end(init_end),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
    .axi_wdata(axi_wdata), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .wr_trig(wr_trig), .wr_len(wr_len), .wr_data(wr_data), .wr_data_en(wr_data_en),
    .wr_addr(wr_addr), .wr_ready(wr_ready), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } aw_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } w_exp_t;

  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];

  int total = 0;
  int bad   = 0;
  int n_issued = 0;
  int done_seen = 0;
  int aw_hs = 0;
  int beats_seen = 0;
  int beats_issued = 0;
  logic busy = 1'b0;
  logic awv_prev = 1'b0;
  logic [DW-1:0] next_word = 16'd1;
  logic [DW-1:0] user_word = 16'd1;

  // Responder configuration
  int   aw_delay = 0;
  int   b_delay  = 0;
  logic w_toggle = 1'b0;

  assign wr_data = user_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // User side and AXI slave responder; inputs change 1 time unit after the rising edge.
  initial begin : responder
    logic en_s;
    int   aw_wait;
    int   b_wait;
    aw_wait = 0;
    b_wait  = 0;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    forever begin
      @(negedge clk);
      en_s = wr_data_en;
      @(posedge clk);
      #1;
      if (en_s) user_word = user_word + 16'd1;
      aw_wait     = axi_awvalid ? aw_wait + 1 : 0;
      axi_awready = (aw_delay == 0) || (aw_wait > aw_delay);
      b_wait      = axi_bready ? b_wait + 1 : 0;
      axi_bvalid  = (b_delay == 0) || (b_wait > b_delay);
      axi_wready  = w_toggle ? ~axi_wready : 1'b1;
    end
  end

  // Monitor: compares every presented output against the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      check("wr_ready", {31'd0, wr_ready}, {31'd0, init_end && !busy});
      check("wr_data_en", {31'd0, wr_data_en}, {31'd0, axi_wvalid && axi_wready});
      if (wr_done) begin
        check("done_when_busy", {31'd0, busy}, 32'd1);
        done_seen++;
        busy = 1'b0;
      end
      if (wr_trig && wr_ready) busy = 1'b1;

      if (axi_awvalid) begin
        if (!awv_prev) check("done_before_aw", done_seen, aw_hs);
        if (aw_q.size() == 0) begin
          timeout_fail("aw_unexpected");
        end else begin
          check("awaddr", {5'd0, axi_awaddr}, {5'd0, aw_q[0].addr});
          check("awlen", {24'd0, axi_awlen}, {24'd0, aw_q[0].len});
          if (axi_awready) begin
            void'(aw_q.pop_front());
            aw_hs++;
          end
        end
      end
      awv_prev = axi_awvalid;

      if (axi_wvalid) begin
        if (w_q.size() == 0) begin
          timeout_fail("w_unexpected");
        end else begin
          check("wdata", {16'd0, axi_wdata}, {16'd0, w_q[0].data});
          check("wlast", {31'd0, axi_wlast}, {31'd0, w_q[0].last});
          if (axi_wready) begin
            void'(w_q.pop_front());
            beats_seen++;
          end
        end
      end
    end
  end

  task automatic issue(input logic [AW-1:0] addr, input logic [7:0] len, input int exp_len);
    bit ok;
    aw_q.push_back('{addr, 8'(exp_len)});
    for (int i = 0; i <= exp_len; i++) begin
      w_q.push_back('{next_word, (i == exp_len)});
      next_word = next_word + 16'd1;
    end
    n_issued++;
    beats_issued += exp_len + 1;
    wr_addr = addr;
    wr_len  = len;
    wr_trig = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (wr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("accept");
    @(posedge clk);
    #1;
    wr_trig = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (aw_q.size() == 0 && w_q.size() == 0 && done_seen == n_issued) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("drain");
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rstn     = 1'b0;
    init_end = 1'b0;
    wr_trig  = 1'b1;
    wr_addr  = '0;
    wr_len   = 8'd8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awvalid", {31'd0, axi_awvalid}, 32'd0);
    check("rst_wvalid", {31'd0, axi_wvalid}, 32'd0);
    check("rst_bready", {31'd0, axi_bready}, 32'd0);
    check("rst_wlast", {31'd0, axi_wlast}, 32'd0);
    check("rst_done", {31'd0, wr_done}, 32'd0);
    check("rst_awaddr", {5'd0, axi_awaddr}, 32'd0);
    check("rst_awlen", {24'd0, axi_awlen}, 32'd0);
    #1 rstn = 1'b1;

    // Trigger held while init is pending: nothing may be accepted.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check("no_aw_before_init", {31'd0, axi_awvalid}, 32'd0);
    end
    @(posedge clk);
    #1 init_end = 1'b1;

    // Full burst, then two back-to-back requests.
    issue(27'd0, 8'd8, 7);
    issue(27'd16, 8'd8, 7);
    issue(27'd32, 8'd8, 7);
    drain();

    // Write-data stalls on alternate cycles.
    w_toggle = 1'b1;
    issue(27'd48, 8'd8, 7);
    drain();
    w_toggle = 1'b0;

    // Slow address and response channels.
    aw_delay = 5;
    b_delay  = 3;
    issue(27'd64, 8'd8, 7);
    drain();
    aw_delay = 0;
    b_delay  = 0;

    // Length boundaries: zero becomes one beat, oversize clamps to eight.
    issue(27'd80, 8'd0, 0);
    issue(27'd96, 8'd20, 7);
    drain();

    check("bursts_done", done_seen, n_issued);
    check("beats_total", beats_seen, beats_issued);
    check("aw_count", aw_hs, n_issued);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
